pq_cmd_scheduler: RTL and testbench
===================================

// Module: pq_cmd_scheduler
// PURPOSE
// Front-end stage directly upstream of pipelined_bram_tree. Accepts ENQUEUE/DEQUEUE/REPLACE
// commands over a valid/ready stream, buffers them in a command FIFO, and issues them to the
// tree as single-cycle i_wrt/i_read strobes spaced by the tree's settle time. Captures the root
// value on every DEQUEUE/REPLACE and returns it on a valid/ready response port.
// PARAMETERS
// DATA_WIDTH  16  key width, equal to the tree's DATA_WIDTH
// QUEUE_SIZE  31  tree capacity; bounds the local occupancy counter
// FIFO_DEPTH  8   command FIFO entries; power of two, >=2
// ISSUE_GAP   24  idle cycles after each tree strobe before the next strobe may issue
// PORTS
// CLK        in   1                  clock, all logic on rising edge
// RST        in   1                  asynchronous, active-high reset
// s_valid    in   1                  command valid
// s_ready    out  1                  command accepted when s_valid&&s_ready
// s_op       in   2                  00 ENQ, 01 DEQ, 10 REPLACE, 11 reserved
// s_data     in   DATA_WIDTH         key for ENQ/REPLACE, ignored for DEQ
// m_valid    out  1                  response valid, held until m_ready
// m_ready    in   1                  response consumer ready
// m_data     out  DATA_WIDTH         root value removed by DEQ/REPLACE (0 on miss)
// m_miss     out  1                  response is for an empty queue
// o_wrt      out  1                  to tree i_wrt
// o_read     out  1                  to tree i_read
// o_data     out  DATA_WIDTH         to tree i_data
// i_top      in   DATA_WIDTH         from tree o_data (current root)
// o_count    out  $clog2(QUEUE_SIZE+1)  locally tracked tree occupancy
// o_err      out  1                  one-cycle pulse: ENQ dropped on full, or reserved op
// BEHAVIOUR
// - Reset (async assert, sync release): FIFO empty, count 0, state IDLE; s_ready, m_valid,
//   m_data, m_miss, o_wrt, o_read, o_data, o_err all 0. Reset mid-WAIT abandons the command;
//   the tree must be reset in the same event.
// - Command FIFO: circular, s_ready = !fifo_full; no bypass; push and pop in same cycle legal.
// - FSM IDLE: if FIFO non-empty and (head is ENQ or response slot free) -> ISSUE, else stay.
// - FSM ISSUE (1 cycle): act on FIFO head, pop it; if a tree strobe was driven, load gap
//   counter with ISSUE_GAP -> WAIT, else -> IDLE.
//   ENQ, count<QUEUE_SIZE: o_wrt=1, o_data=key, count+1.
//   ENQ, count==QUEUE_SIZE: no strobe, o_err pulse, dropped, count unchanged.
//   DEQ, count>0: o_read=1, response <= {i_top, miss=0}, count-1.
//   DEQ, count==0: no strobe, response <= {0, miss=1}.
//   REPLACE, count>0: o_wrt=o_read=1, o_data=key, response <= {i_top, 0}, count unchanged.
//   REPLACE, count==0: issued as ENQ (o_wrt only), response <= {0, 1}, count 1.
//   Reserved op: no strobe, o_err pulse, discarded.
// - FSM WAIT: decrement gap counter; at 1 -> IDLE. Strobes therefore issue at least
//   ISSUE_GAP+2 cycles apart; strobes are high exactly one cycle, 0 otherwise.
// - Strobe command to first strobe latency: 2 cycles (accept, IDLE->ISSUE) from empty/idle.
// - Response: single register; m_valid set in ISSUE, cleared on m_valid&&m_ready; DEQ/REPLACE
//   heads stall in IDLE while m_valid=1 and m_ready=0. m_data/m_miss stable while m_valid=1.
// - o_count never exceeds QUEUE_SIZE nor wraps below 0; tree full/empty are not used.
// TESTING
// - Reset, ENQ 100,300,200 back-to-back -> three o_wrt pulses exactly 26 cycles apart, o_count=3.
// - After above, DEQ x3 with m_ready=1 -> m_data 300,200,100, m_miss=0; 4th DEQ -> m_data=0,
//   m_miss=1, no o_read pulse, next command issues without gap.
// - Fill 31 ENQs then ENQ 5 -> o_err one-cycle pulse, no o_wrt, o_count stays 31.
// - Root 900, REPLACE 50 -> single cycle o_wrt=o_read=1, o_data=50, m_data=900, o_count same.
// - Hold m_ready=0, queue DEQ,DEQ,ENQ 7 -> second DEQ stalls, FIFO fills, s_ready drops at 8
//   entries; release m_ready -> responses drain in order, no command lost.
// - Assert RST during WAIT with 3 FIFO entries -> all outputs 0 same cycle, o_count=0, s_ready=1
//   after release.

Source files
------------

// File: rtl/pq_cmd_scheduler.sv
// pq_cmd_scheduler: command front-end for pipelined_bram_tree.
// Buffers ENQ/DEQ/REPLACE commands in a small circular FIFO, issues them to the
// tree as single-cycle strobes separated by the tree settle time, tracks the
// tree occupancy locally and returns the removed root on a valid/ready port.
// RST asserts asynchronously; its release is expected to be synchronous to CLK.
module pq_cmd_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int QUEUE_SIZE = 31,
    parameter int FIFO_DEPTH = 8,
    parameter int ISSUE_GAP  = 24
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [1:0]                        s_op,
    input  logic [DATA_WIDTH-1:0]             s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              m_miss,
    output logic                              o_wrt,
    output logic                              o_read,
    output logic [DATA_WIDTH-1:0]             o_data,
    input  logic [DATA_WIDTH-1:0]             i_top,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count,
    output logic                              o_err
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int FCW = PW + 1;
    localparam int CW  = $clog2(QUEUE_SIZE + 1);
    localparam int GW  = $clog2(ISSUE_GAP + 1);

    typedef enum logic [1:0] {
        OP_ENQ = 2'b00,
        OP_DEQ = 2'b01,
        OP_REP = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    // Command FIFO storage and bookkeeping
    logic [1:0]            r_fifoOp  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifoKey [FIFO_DEPTH];
    logic [PW-1:0]         r_wrPtr;
    logic [PW-1:0]         r_rdPtr;
    logic [FCW-1:0]        r_fifoCnt;

    // Scheduler state
    state_e                r_state;
    state_e                w_stateNext;
    logic [GW-1:0]         r_gap;
    logic [GW-1:0]         w_gapNext;
    logic [CW-1:0]         r_count;

    // Response register
    logic                  r_mValid;
    logic [DATA_WIDTH-1:0] r_mData;
    logic                  r_mMiss;

    // Handshake and decode wires
    logic                  w_fifoFull;
    logic                  w_fifoEmpty;
    logic                  w_push;
    logic                  w_pop;
    op_e                   w_headOp;
    logic [DATA_WIDTH-1:0] w_headKey;
    logic                  w_respFree;
    logic                  w_canIssue;
    logic                  w_treeFull;
    logic                  w_treeEmpty;

    // Per-command actions, only non-zero in the ISSUE cycle
    logic                  w_doWrt;
    logic                  w_doRead;
    logic                  w_err;
    logic                  w_respLoad;
    logic [DATA_WIDTH-1:0] w_respData;
    logic                  w_respMiss;
    logic                  w_cntInc;
    logic                  w_cntDec;

    assign w_fifoFull  = (r_fifoCnt == FCW'(FIFO_DEPTH));
    assign w_fifoEmpty = (r_fifoCnt == '0);
    assign s_ready     = ~w_fifoFull & ~RST;
    assign w_push      = s_valid & s_ready;
    assign w_pop       = (r_state == ST_ISSUE);

    assign w_headOp    = op_e'(r_fifoOp[r_rdPtr]);
    assign w_headKey   = r_fifoKey[r_rdPtr];

    // A DEQ/REPLACE may only issue when its response has somewhere to go
    assign w_respFree  = ~r_mValid | m_ready;
    assign w_canIssue  = ~w_fifoEmpty & ((w_headOp == OP_ENQ) | w_respFree);

    assign w_treeFull  = (r_count == CW'(QUEUE_SIZE));
    assign w_treeEmpty = (r_count == '0);

    // FIFO payload write; storage needs no reset since occupancy is tracked separately
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifoOp[r_wrPtr]  <= s_op;
            r_fifoKey[r_wrPtr] <= s_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fifoCnt <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifoCnt <= r_fifoCnt + FCW'(1);
                2'b01:   r_fifoCnt <= r_fifoCnt - FCW'(1);
                default: r_fifoCnt <= r_fifoCnt;
            endcase
        end
    end

    // Decode the FIFO head into tree strobes, response and occupancy updates
    always_comb begin
        w_doWrt    = 1'b0;
        w_doRead   = 1'b0;
        w_err      = 1'b0;
        w_respLoad = 1'b0;
        w_respData = '0;
        w_respMiss = 1'b0;
        w_cntInc   = 1'b0;
        w_cntDec   = 1'b0;
        if (r_state == ST_ISSUE) begin
            case (w_headOp)
                OP_ENQ: begin
                    if (!w_treeFull) begin
                        w_doWrt  = 1'b1;
                        w_cntInc = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                OP_DEQ: begin
                    w_respLoad = 1'b1;
                    if (!w_treeEmpty) begin
                        w_doRead   = 1'b1;
                        w_respData = i_top;
                        w_cntDec   = 1'b1;
                    end else begin
                        w_respMiss = 1'b1;
                    end
                end
                OP_REP: begin
                    w_respLoad = 1'b1;
                    w_doWrt    = 1'b1;
                    if (!w_treeEmpty) begin
                        w_doRead   = 1'b1;
                        w_respData = i_top;
                    end else begin
                        w_respMiss = 1'b1;
                        w_cntInc   = 1'b1;
                    end
                end
                default: begin
                    w_err = 1'b1;
                end
            endcase
        end
    end

    // Next-state and gap counter: any strobe forces ISSUE_GAP idle cycles in WAIT
    always_comb begin
        w_stateNext = r_state;
        w_gapNext   = r_gap;
        case (r_state)
            ST_IDLE: begin
                if (w_canIssue) begin
                    w_stateNext = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_doWrt || w_doRead) begin
                    w_stateNext = ST_WAIT;
                    w_gapNext   = GW'(ISSUE_GAP);
                end else begin
                    w_stateNext = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_gapNext = r_gap - GW'(1);
                if (r_gap <= GW'(1)) begin
                    w_stateNext = ST_IDLE;
                    w_gapNext   = '0;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_gapNext   = '0;
            end
        endcase
    end

    // State and gap counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_gap   <= w_gapNext;
        end
    end

    // Local mirror of tree occupancy, saturating by construction of the decode
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (w_cntInc) begin
            r_count <= r_count + CW'(1);
        end else if (w_cntDec) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Response slot: loaded in ISSUE, released on handshake, payload frozen while valid
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mValid <= 1'b0;
            r_mData  <= '0;
            r_mMiss  <= 1'b0;
        end else if (w_respLoad) begin
            r_mValid <= 1'b1;
            r_mData  <= w_respData;
            r_mMiss  <= w_respMiss;
        end else if (r_mValid && m_ready) begin
            r_mValid <= 1'b0;
        end
    end

    assign m_valid = r_mValid;
    assign m_data  = r_mData;
    assign m_miss  = r_mMiss;
    assign o_wrt   = w_doWrt;
    assign o_read  = w_doRead;
    assign o_data  = w_doWrt ? w_headKey : '0;
    assign o_err   = w_err;
    assign o_count = r_count;

endmodule

// File: tb/tb_pq_cmd_scheduler.sv
// tb_pq_cmd_scheduler: randomized and directed bench for pq_cmd_scheduler.
// A behavioural max-priority-queue model predicts strobes, responses and
// errors per accepted command; a separate tree model drives i_top from the
// strobes the DUT actually emits.
module tb_pq_cmd_scheduler;

    localparam int DW  = 16;
    localparam int QS  = 31;
    localparam int FD  = 8;
    localparam int GAP = 24;
    localparam int CW  = $clog2(QS + 1);

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1:0]    s_op = 2'b00;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_miss;
    logic          o_wrt;
    logic          o_read;
    logic [DW-1:0] o_data;
    logic [DW-1:0] i_top = '0;
    logic [CW-1:0] o_count;
    logic          o_err;

    pq_cmd_scheduler #(
        .DATA_WIDTH(DW),
        .QUEUE_SIZE(QS),
        .FIFO_DEPTH(FD),
        .ISSUE_GAP (GAP)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_op   (s_op),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_miss (m_miss),
        .o_wrt  (o_wrt),
        .o_read (o_read),
        .o_data (o_data),
        .i_top  (i_top),
        .o_count(o_count),
        .o_err  (o_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          wrt;
        logic          rd;
        logic [DW-1:0] data;
    } strobe_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          miss;
    } resp_t;

    int      vecCount = 0;
    int      missCount = 0;
    int      cyc = 0;
    int      refQ[$];
    int      treeQ[$];
    strobe_t expStrobe[$];
    resp_t   expResp[$];
    int      strobeCyc[$];
    int      lastStrobeCyc = -1000;
    int      lastAcceptCyc = 0;
    int      expErr = 0;
    int      obsErr = 0;
    int      mReadyMode = 1;
    bit      prevErr = 1'b0;
    bit      prevHeld = 1'b0;
    logic [DW-1:0] heldData;
    logic          heldMiss;

    logic          sWrt, sRd, sErr, sMv, sMr, sMiss;
    logic [DW-1:0] sData, sMd;

    // Single comparison point: counts every vector and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic int refMaxIdx();
        int best = 0;
        for (int i = 1; i < refQ.size(); i++) begin
            if (refQ[i] > refQ[best]) best = i;
        end
        return best;
    endfunction

    function automatic int treeMaxIdx();
        int best = 0;
        for (int i = 1; i < treeQ.size(); i++) begin
            if (treeQ[i] > treeQ[best]) best = i;
        end
        return best;
    endfunction

    // Priority-queue semantics of one accepted command
    task automatic modelCommand(input logic [1:0] op, input logic [DW-1:0] key);
        strobe_t st;
        resp_t   rs;
        int      idx;
        case (op)
            2'b00: begin
                if (refQ.size() < QS) begin
                    st.wrt = 1'b1; st.rd = 1'b0; st.data = key;
                    expStrobe.push_back(st);
                    refQ.push_back(int'(key));
                end else begin
                    expErr++;
                end
            end
            2'b01: begin
                if (refQ.size() > 0) begin
                    idx = refMaxIdx();
                    st.wrt = 1'b0; st.rd = 1'b1; st.data = '0;
                    expStrobe.push_back(st);
                    rs.data = DW'(refQ[idx]); rs.miss = 1'b0;
                    refQ.delete(idx);
                end else begin
                    rs.data = '0; rs.miss = 1'b1;
                end
                expResp.push_back(rs);
            end
            2'b10: begin
                if (refQ.size() > 0) begin
                    idx = refMaxIdx();
                    st.wrt = 1'b1; st.rd = 1'b1; st.data = key;
                    rs.data = DW'(refQ[idx]); rs.miss = 1'b0;
                    refQ.delete(idx);
                end else begin
                    st.wrt = 1'b1; st.rd = 1'b0; st.data = key;
                    rs.data = '0; rs.miss = 1'b1;
                end
                refQ.push_back(int'(key));
                expStrobe.push_back(st);
                expResp.push_back(rs);
            end
            default: expErr++;
        endcase
    endtask

    // Offer one command for up to maxCycles cycles; model it once accepted
    task automatic applyStimulus(input logic [1:0] op, input logic [DW-1:0] key,
                                 input int maxCycles, output bit accepted);
        accepted = 1'b0;
        @(negedge CLK);
        s_valid = 1'b1;
        s_op    = op;
        s_data  = key;
        for (int i = 0; i < maxCycles && !accepted; i++) begin
            if (i > 0) @(negedge CLK);
            if (s_ready) begin
                @(posedge CLK);
                #1;
                accepted      = 1'b1;
                lastAcceptCyc = cyc;
                modelCommand(op, key);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic sendCmd(input logic [1:0] op, input logic [DW-1:0] key);
        bit acc;
        applyStimulus(op, key, 600, acc);
        checkOutput("cmdAccepted", 32'(acc), 1);
    endtask

    // Wait for all predicted activity to appear, then compare steady-state outputs
    task automatic waitDrain();
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (expStrobe.size() == 0 && expResp.size() == 0) break;
        end
        repeat (GAP + 40) @(negedge CLK);
        checkOutput("drainPending", 32'(expStrobe.size() + expResp.size()), 0);
        checkOutput("count", 32'(o_count), 32'(refQ.size()));
        checkOutput("errCount", 32'(obsErr), 32'(expErr));
        checkOutput("idleMValid", 32'(m_valid), 0);
        checkOutput("idleReady", 32'(s_ready), 1);
    endtask

    task automatic clearModels();
        refQ.delete();
        treeQ.delete();
        expStrobe.delete();
        expResp.delete();
        lastStrobeCyc = -1000;
        prevErr  = 1'b0;
        prevHeld = 1'b0;
        i_top    = '0;
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, "_wrt"},    32'(o_wrt), 0);
        checkOutput({phase, "_read"},   32'(o_read), 0);
        checkOutput({phase, "_err"},    32'(o_err), 0);
        checkOutput({phase, "_oData"},  32'(o_data), 0);
        checkOutput({phase, "_mValid"}, 32'(m_valid), 0);
        checkOutput({phase, "_mData"},  32'(m_data), 0);
        checkOutput({phase, "_mMiss"},  32'(m_miss), 0);
        checkOutput({phase, "_count"},  32'(o_count), 0);
        checkOutput({phase, "_sReady"}, 32'(s_ready), 0);
    endtask

    // Consumer readiness: 0 = stalled, 1 = always ready, 2 = random
    initial begin
        forever begin
            @(negedge CLK);
            if (mReadyMode == 2) m_ready = 1'($urandom_range(0, 1));
            else                 m_ready = (mReadyMode == 1);
        end
    end

    // Monitor: check strobes, errors and responses at each edge, then update the tree
    always @(posedge CLK) begin
        cyc++;
        if (!RST) begin
            sWrt = o_wrt; sRd = o_read; sData = o_data; sErr = o_err;
            sMv = m_valid; sMr = m_ready; sMd = m_data; sMiss = m_miss;
            if (sWrt || sRd) begin
                checkOutput("strobeGapOk", 32'(cyc - lastStrobeCyc >= GAP + 2), 1);
                lastStrobeCyc = cyc;
                strobeCyc.push_back(cyc);
                if (expStrobe.size() == 0) begin
                    checkOutput("strobeUnexpected", 1, 0);
                end else begin
                    strobe_t es;
                    es = expStrobe.pop_front();
                    checkOutput("strobeKind", {30'd0, sWrt, sRd}, {30'd0, es.wrt, es.rd});
                    if (es.wrt) checkOutput("strobeData", 32'(sData), 32'(es.data));
                end
            end
            if (sErr) begin
                checkOutput("errSingleCycle", 32'(prevErr), 0);
                obsErr++;
            end
            prevErr = sErr;
            if (sMv && prevHeld) begin
                checkOutput("respStable", {15'd0, sMd, sMiss}, {15'd0, heldData, heldMiss});
            end
            if (sMv && sMr) begin
                prevHeld = 1'b0;
                if (expResp.size() == 0) begin
                    checkOutput("respUnexpected", 1, 0);
                end else begin
                    resp_t er;
                    er = expResp.pop_front();
                    checkOutput("respData", 32'(sMd), 32'(er.data));
                    checkOutput("respMiss", 32'(sMiss), 32'(er.miss));
                end
            end else if (sMv) begin
                prevHeld = 1'b1;
                heldData = sMd;
                heldMiss = sMiss;
            end else begin
                prevHeld = 1'b0;
            end
            #1;
            if (!RST) begin
                if (sRd && treeQ.size() > 0) treeQ.delete(treeMaxIdx());
                if (sWrt) treeQ.push_back(int'(sData));
                i_top = (treeQ.size() > 0) ? DW'(treeQ[treeMaxIdx()]) : '0;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  t0;
        int  total;
        bit  acc;
        int  r;
        logic [1:0] op;

        // Reset values while reset is held
        mReadyMode = 1;
        repeat (3) @(negedge CLK);
        checkAllZero("reset");
        RST = 1'b0;
        #1;
        checkOutput("readyAfterReset", 32'(s_ready), 1);

        // Three back-to-back ENQs: first strobe 2 cycles after accept, then 26 apart
        strobeCyc.delete();
        sendCmd(2'b00, 16'd100);
        t0 = lastAcceptCyc;
        sendCmd(2'b00, 16'd300);
        sendCmd(2'b00, 16'd200);
        waitDrain();
        checkOutput("enqStrobes", 32'(strobeCyc.size()), 3);
        if (strobeCyc.size() == 3) begin
            checkOutput("firstLatency", 32'(strobeCyc[0] - t0), 2);
            checkOutput("spacing01", 32'(strobeCyc[1] - strobeCyc[0]), GAP + 2);
            checkOutput("spacing12", 32'(strobeCyc[2] - strobeCyc[1]), GAP + 2);
        end

        // Drain in priority order, then a miss that must not stall the next command
        sendCmd(2'b01, 16'd0);
        sendCmd(2'b01, 16'd0);
        sendCmd(2'b01, 16'd0);
        waitDrain();
        strobeCyc.delete();
        sendCmd(2'b01, 16'd0);
        t0 = lastAcceptCyc;
        sendCmd(2'b00, 16'd42);
        waitDrain();
        checkOutput("missStrobes", 32'(strobeCyc.size()), 1);
        if (strobeCyc.size() == 1) checkOutput("missNoGap", 32'(strobeCyc[0] - t0), 4);

        // REPLACE on a non-empty tree: combined strobe returning the old root
        sendCmd(2'b00, 16'd900);
        sendCmd(2'b10, 16'd50);
        waitDrain();

        // Response back-pressure: second DEQ stalls and the FIFO fills
        mReadyMode = 0;
        sendCmd(2'b01, 16'd0);
        sendCmd(2'b01, 16'd0);
        sendCmd(2'b00, 16'd7);
        total = 3;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(2'b00, DW'($urandom_range(0, 65535)), 1, acc);
            if (!acc) break;
            total++;
        end
        checkOutput("bpAccepted", 32'(total), FD + 1);
        checkOutput("bpReadyLow", 32'(s_ready), 0);
        mReadyMode = 2;
        waitDrain();

        // Fill to capacity, then overflow ENQ and a reserved opcode
        mReadyMode = 1;
        while (refQ.size() < QS) sendCmd(2'b00, DW'($urandom_range(0, 65535)));
        waitDrain();
        strobeCyc.delete();
        t0 = obsErr;
        sendCmd(2'b00, 16'd5);
        sendCmd(2'b11, 16'd9);
        waitDrain();
        checkOutput("overflowNoStrobe", 32'(strobeCyc.size()), 0);
        checkOutput("overflowErrs", 32'(obsErr - t0), 2);

        // Randomized command mix with varying consumer readiness
        for (int n = 0; n < 250; n++) begin
            if (n % 20 == 0) mReadyMode = int'($urandom_range(1, 2));
            r = int'($urandom_range(0, 99));
            if (r < 40)      op = 2'b00;
            else if (r < 75) op = 2'b01;
            else if (r < 95) op = 2'b10;
            else             op = 2'b11;
            sendCmd(op, DW'($urandom_range(0, 65535)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) @(negedge CLK);
        end
        mReadyMode = 1;
        waitDrain();

        // Reset while waiting out the gap with three commands still queued
        sendCmd(2'b10, 16'd11);
        sendCmd(2'b10, 16'd12);
        sendCmd(2'b10, 16'd13);
        sendCmd(2'b10, 16'd14);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        clearModels();
        #1;
        checkAllZero("midReset");
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checkOutput("readyAfterMidReset", 32'(s_ready), 1);
        checkOutput("countAfterMidReset", 32'(o_count), 0);
        repeat (GAP + 20) @(negedge CLK);
        checkOutput("quietAfterReset", 32'(m_valid | o_wrt | o_read), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
